// File: rtl/lc3_pkg.sv
// Shared types and constants for the LC-3 datapath: mux/ALU select encodings,
// condition-code bit positions and memory handshake states.
`default_nettype none

package lc3_pkg;

  localparam int          DEFAULT_WIDTH    = 16;
  localparam logic [15:0] DEFAULT_RESET_PC = 16'h3000;

  localparam int CC_N = 2;
  localparam int CC_Z = 1;
  localparam int CC_P = 0;

  typedef enum logic [1:0] {
    ALUK_AND  = 2'b00,
    ALUK_NOT  = 2'b01,
    ALUK_ADD  = 2'b10,
    ALUK_PASS = 2'b11
  } aluk_e;

  typedef enum logic [1:0] {
    PCMUX_BUS  = 2'b00,
    PCMUX_ADDR = 2'b01,
    PCMUX_INC  = 2'b10,
    PCMUX_HOLD = 2'b11
  } pcmux_e;

  typedef enum logic [1:0] {
    A2M_OFF11 = 2'b00,
    A2M_OFF9  = 2'b01,
    A2M_OFF6  = 2'b10,
    A2M_ZERO  = 2'b11
  } a2m_e;

  typedef enum logic {
    MARMUX_ZEXT8 = 1'b0,
    MARMUX_ADDR  = 1'b1
  } marmux_e;

  typedef enum logic [1:0] {
    MEM_IDLE  = 2'b00,
    MEM_BUSY  = 2'b01,
    MEM_READY = 2'b10
  } mem_state_e;

endpackage

`default_nettype wire

// File: rtl/lc3_datapath_p_if.sv
// Control/status bundle between the LC-3 control FSM (master) and the datapath (slave).
`default_nettype none

interface lc3_datapath_p_if #(
  parameter int WIDTH    = 16,
  parameter int NUM_REGS = 8
);
  import lc3_pkg::*;

  localparam int RSEL_W = $clog2(NUM_REGS);

  logic              ld_ir, ld_reg, ld_pc, ld_mar, ld_mdr, ld_cc, ld_ben;
  logic [RSEL_W-1:0] dr, sr1, sr2;
  aluk_e             aluk;
  logic              a1m_sel;
  a2m_e              a2m_sel;
  pcmux_e            pcmux_sel;
  marmux_e           marmux_sel;
  logic              gate_pc, gate_mdr, gate_alu, gate_marmux;
  logic              mem_en, mem_rw;

  logic [WIDTH-1:0]  ir;
  logic [WIDTH-1:0]  bus;
  logic [2:0]        nzp;
  logic              ben;
  logic              mem_ready;
  logic              bus_err;

  modport master (
    output ld_ir, ld_reg, ld_pc, ld_mar, ld_mdr, ld_cc, ld_ben,
    output dr, sr1, sr2, aluk, a1m_sel, a2m_sel, pcmux_sel, marmux_sel,
    output gate_pc, gate_mdr, gate_alu, gate_marmux, mem_en, mem_rw,
    input  ir, bus, nzp, ben, mem_ready, bus_err
  );

  modport slave (
    input  ld_ir, ld_reg, ld_pc, ld_mar, ld_mdr, ld_cc, ld_ben,
    input  dr, sr1, sr2, aluk, a1m_sel, a2m_sel, pcmux_sel, marmux_sel,
    input  gate_pc, gate_mdr, gate_alu, gate_marmux, mem_en, mem_rw,
    output ir, bus, nzp, ben, mem_ready, bus_err
  );

endinterface

`default_nettype wire

// File: rtl/lc3_mem_lat.sv
// Local word memory with a fixed-latency access handshake: accept, count, one-cycle ready, abort on en drop.
`default_nettype none

module lc3_mem_lat
  import lc3_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int DEPTH   = 65536,
  parameter int LATENCY = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic                     rw,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     ready
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam int CNT_W  = $clog2(LATENCY + 1);

  logic [WIDTH-1:0]  mem [DEPTH];
  mem_state_e        state;
  logic [CNT_W-1:0]  cnt;
  logic              op_wr;
  logic [ADDR_W-1:0] addr_q;
  logic [WIDTH-1:0]  wdata_q;

  // Operands are snapshotted at accept so MAR/MDR may change mid-access.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= MEM_IDLE;
      cnt     <= '0;
      op_wr   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      ready   <= 1'b0;
    end else begin
      case (state)
        MEM_IDLE: begin
          ready <= 1'b0;
          if (en) begin
            state   <= MEM_BUSY;
            cnt     <= '0;
            op_wr   <= rw;
            addr_q  <= addr;
            wdata_q <= wdata;
          end
        end
        MEM_BUSY: begin
          if (!en) begin
            state <= MEM_IDLE;
          end else if (cnt == CNT_W'(LATENCY - 1)) begin
            state <= MEM_READY;
            ready <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        MEM_READY: begin
          state <= MEM_IDLE;
          ready <= 1'b0;
        end
        default: begin
          state <= MEM_IDLE;
          ready <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (state == MEM_READY && op_wr) begin
      mem[addr_q] <= wdata_q;
    end
  end

  assign rdata = mem[addr_q];

endmodule

`default_nettype wire

// File: rtl/lc3_datapath_p.sv
// LC-3 datapath: IR, regfile, ALU, PC/address path, MAR/MDR and latency memory sharing one muxed bus.
`default_nettype none

module lc3_datapath_p
  import lc3_pkg::*;
#(
  parameter int               WIDTH       = DEFAULT_WIDTH,
  parameter int               NUM_REGS    = 8,
  parameter int               MEM_DEPTH   = 65536,
  parameter int               MEM_LATENCY = 1,
  parameter logic [WIDTH-1:0] RESET_PC    = WIDTH'(DEFAULT_RESET_PC)
) (
  input  logic            clk,
  input  logic            rst_n,
  lc3_datapath_p_if.slave dp
);

  localparam int ADDR_W = $clog2(MEM_DEPTH);

  logic [WIDTH-1:0] ir_q, pc_q, mar_q, mdr_q;
  logic [WIDTH-1:0] regs [NUM_REGS];
  logic [2:0]       nzp_q;
  logic             ben_q, bus_err_q;

  logic [WIDTH-1:0] sr1_val, sr2_val, sr2mux, alu_out;
  logic [WIDTH-1:0] a1_val, a2_val, addr_sum, marmux_out, pcmux_out, bus_val;
  logic [WIDTH-1:0] mem_rdata;
  logic             mem_ready;
  logic [2:0]       cc_next;
  logic [2:0]       gate_cnt;
  logic             conflict;

  assign sr1_val = regs[dp.sr1];
  assign sr2_val = regs[dp.sr2];
  assign sr2mux  = ir_q[5] ? {{(WIDTH-5){ir_q[4]}}, ir_q[4:0]} : sr2_val;

  always_comb begin
    alu_out = sr1_val;
    case (dp.aluk)
      ALUK_AND: alu_out = sr1_val & sr2mux;
      ALUK_NOT: alu_out = ~sr1_val;
      ALUK_ADD: alu_out = sr1_val + sr2mux;
      default:  alu_out = sr1_val;
    endcase
  end

  assign a1_val = dp.a1m_sel ? pc_q : sr1_val;

  always_comb begin
    a2_val = '0;
    case (dp.a2m_sel)
      A2M_OFF11: a2_val = {{(WIDTH-11){ir_q[10]}}, ir_q[10:0]};
      A2M_OFF9:  a2_val = {{(WIDTH-9){ir_q[8]}},   ir_q[8:0]};
      A2M_OFF6:  a2_val = {{(WIDTH-6){ir_q[5]}},   ir_q[5:0]};
      default:   a2_val = '0;
    endcase
  end

  assign addr_sum   = a1_val + a2_val;
  assign marmux_out = (dp.marmux_sel == MARMUX_ADDR) ? addr_sum
                                                     : {{(WIDTH-8){1'b0}}, ir_q[7:0]};

  always_comb begin
    pcmux_out = pc_q;
    case (dp.pcmux_sel)
      PCMUX_BUS:  pcmux_out = bus_val;
      PCMUX_ADDR: pcmux_out = addr_sum;
      PCMUX_INC:  pcmux_out = pc_q + WIDTH'(1);
      default:    pcmux_out = pc_q;
    endcase
  end

  // Fixed priority replaces tristates; any overlap is flagged instead of resolved silently.
  always_comb begin
    bus_val = '0;
    if (dp.gate_pc)           bus_val = pc_q;
    else if (dp.gate_mdr)     bus_val = mdr_q;
    else if (dp.gate_alu)     bus_val = alu_out;
    else if (dp.gate_marmux)  bus_val = marmux_out;
  end

  assign gate_cnt = {2'b00, dp.gate_pc} + {2'b00, dp.gate_mdr}
                  + {2'b00, dp.gate_alu} + {2'b00, dp.gate_marmux};
  assign conflict = (gate_cnt > 3'd1);

  always_comb begin
    cc_next       = 3'b000;
    cc_next[CC_N] = bus_val[WIDTH-1];
    cc_next[CC_Z] = (bus_val == '0);
    cc_next[CC_P] = !bus_val[WIDTH-1] && (bus_val != '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ir_q      <= '0;
      pc_q      <= RESET_PC;
      mar_q     <= '0;
      mdr_q     <= '0;
      nzp_q     <= 3'b010;
      ben_q     <= 1'b0;
      bus_err_q <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else begin
      if (dp.ld_ir)  ir_q  <= bus_val;
      if (dp.ld_pc)  pc_q  <= pcmux_out;
      if (dp.ld_mar) mar_q <= bus_val;
      if (dp.ld_mdr) begin
        if (!dp.mem_en)     mdr_q <= bus_val;
        else if (mem_ready) mdr_q <= mem_rdata;
      end
      if (dp.ld_reg) regs[dp.dr] <= bus_val;
      if (dp.ld_cc)  nzp_q <= cc_next;
      if (dp.ld_ben) begin
        ben_q <= (ir_q[11] & nzp_q[CC_N]) | (ir_q[10] & nzp_q[CC_Z]) | (ir_q[9] & nzp_q[CC_P]);
      end
      if (conflict) bus_err_q <= 1'b1;
    end
  end

  lc3_mem_lat #(
    .WIDTH   (WIDTH),
    .DEPTH   (MEM_DEPTH),
    .LATENCY (MEM_LATENCY)
  ) u_mem (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (dp.mem_en),
    .rw    (dp.mem_rw),
    .addr  (mar_q[ADDR_W-1:0]),
    .wdata (mdr_q),
    .rdata (mem_rdata),
    .ready (mem_ready)
  );

  assign dp.ir        = ir_q;
  assign dp.bus       = bus_val;
  assign dp.nzp       = nzp_q;
  assign dp.ben       = ben_q;
  assign dp.mem_ready = mem_ready;
  assign dp.bus_err   = bus_err_q;

endmodule

`default_nettype wire

// File: tb/tb_lc3_datapath_p.sv
// Directed bench for lc3_datapath_p: constants are built in registers through the ALU, then each path is exercised.
`default_nettype none

module tb_lc3_datapath_p;
  import lc3_pkg::*;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  lc3_datapath_p_if #(.WIDTH(16), .NUM_REGS(8)) dp ();

  lc3_datapath_p #(
    .WIDTH       (16),
    .NUM_REGS    (8),
    .MEM_DEPTH   (65536),
    .MEM_LATENCY (3),
    .RESET_PC    (16'h3000)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .dp    (dp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    dp.ld_ir = 0; dp.ld_reg = 0; dp.ld_pc = 0; dp.ld_mar = 0;
    dp.ld_mdr = 0; dp.ld_cc = 0; dp.ld_ben = 0;
    dp.dr = '0; dp.sr1 = '0; dp.sr2 = '0;
    dp.aluk = ALUK_AND; dp.a1m_sel = 0; dp.a2m_sel = A2M_ZERO;
    dp.pcmux_sel = PCMUX_HOLD; dp.marmux_sel = MARMUX_ZEXT8;
    dp.gate_pc = 0; dp.gate_mdr = 0; dp.gate_alu = 0; dp.gate_marmux = 0;
    dp.mem_en = 0; dp.mem_rw = 0;
  endtask

  task automatic alu_op(input aluk_e op, input logic [2:0] s1, input logic [2:0] s2,
                        input logic [2:0] d, input logic wr_reg, input logic wr_ir, input logic wr_cc);
    idle();
    dp.aluk = op; dp.sr1 = s1; dp.sr2 = s2; dp.dr = d;
    dp.gate_alu = 1; dp.ld_reg = wr_reg; dp.ld_ir = wr_ir; dp.ld_cc = wr_cc;
    tick();
    idle();
  endtask

  // R6 = 1 is the increment used to assemble constants by shift-and-add.
  task automatic init_consts();
    alu_op(ALUK_PASS, 3'd0, 3'd0, 3'd0, 1'b0, 1'b1, 1'b0);
    alu_op(ALUK_NOT,  3'd0, 3'd0, 3'd7, 1'b1, 1'b0, 1'b0);
    alu_op(ALUK_ADD,  3'd7, 3'd7, 3'd7, 1'b1, 1'b0, 1'b0);
    alu_op(ALUK_NOT,  3'd7, 3'd0, 3'd6, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic set_reg(input logic [2:0] d, input logic [15:0] v);
    alu_op(ALUK_PASS, 3'd0, 3'd0, 3'd0, 1'b0, 1'b1, 1'b0);
    alu_op(ALUK_PASS, 3'd0, 3'd0, d, 1'b1, 1'b0, 1'b0);
    for (int i = 15; i >= 0; i--) begin
      alu_op(ALUK_ADD, d, d, d, 1'b1, 1'b0, 1'b0);
      if (v[i]) alu_op(ALUK_ADD, d, 3'd6, d, 1'b1, 1'b0, 1'b0);
    end
  endtask

  task automatic load_from_r5(input logic [15:0] v, input int which);
    set_reg(3'd5, v);
    idle();
    dp.aluk = ALUK_PASS; dp.sr1 = 3'd5; dp.gate_alu = 1;
    dp.ld_ir  = (which == 0);
    dp.ld_mar = (which == 1);
    dp.ld_mdr = (which == 2);
    tick();
    idle();
  endtask

  task automatic set_ir(input logic [15:0] v);  load_from_r5(v, 0); endtask
  task automatic set_mar(input logic [15:0] v); load_from_r5(v, 1); endtask
  task automatic set_mdr(input logic [15:0] v); load_from_r5(v, 2); endtask

  // src: 0 PC, 1 MDR, 2 register r through ALU pass
  task automatic obs(input int src, input logic [2:0] r, output logic [15:0] v);
    idle();
    dp.gate_pc  = (src == 0);
    dp.gate_mdr = (src == 1);
    dp.gate_alu = (src == 2);
    dp.aluk = ALUK_PASS; dp.sr1 = r;
    #1;
    v = dp.bus;
    idle();
  endtask

  task automatic mem_access(input logic wr, output int lat);
    idle();
    dp.mem_en = 1; dp.mem_rw = wr; dp.ld_mdr = !wr;
    tick();
    lat = 0;
    while (!dp.mem_ready && lat < 20) begin
      tick();
      lat++;
    end
    tick();
    idle();
  endtask

  task automatic mem_write(input logic [15:0] a, input logic [15:0] d, input string tag);
    int lat;
    set_mar(a);
    set_mdr(d);
    mem_access(1'b1, lat);
    check(tag, 16'(lat), 16'd3);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] v;
    int          lat;
    logic        seen;
    total = 0;
    bad   = 0;
    idle();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    check("rst_ir", dp.ir, 16'h0000);
    check("rst_nzp", {13'b0, dp.nzp}, 16'h0002);
    check("rst_ben", {15'b0, dp.ben}, 16'h0000);
    check("rst_bus_err", {15'b0, dp.bus_err}, 16'h0000);
    check("rst_mem_ready", {15'b0, dp.mem_ready}, 16'h0000);
    obs(0, 3'd0, v);
    check("rst_pc", v, 16'h3000);

    init_consts();
    obs(2, 3'd6, v);
    check("const_r6", v, 16'h0001);

    // ADD with immediates
    set_reg(3'd1, 16'd5);
    set_ir(16'h1261);
    check("ir_load", dp.ir, 16'h1261);
    alu_op(ALUK_ADD, 3'd1, 3'd0, 3'd1, 1'b1, 1'b0, 1'b1);
    obs(2, 3'd1, v);
    check("add_imm_pos", v, 16'h0006);
    check("nzp_pos", {13'b0, dp.nzp}, 16'h0001);
    set_reg(3'd1, 16'd1);
    set_ir(16'h127E);
    alu_op(ALUK_ADD, 3'd1, 3'd0, 3'd1, 1'b1, 1'b0, 1'b1);
    obs(2, 3'd1, v);
    check("add_imm_neg", v, 16'hFFFF);
    check("nzp_neg", {13'b0, dp.nzp}, 16'h0004);
    set_reg(3'd1, 16'd1);
    set_ir(16'h127F);
    alu_op(ALUK_ADD, 3'd1, 3'd0, 3'd1, 1'b1, 1'b0, 1'b1);
    obs(2, 3'd1, v);
    check("add_imm_zero", v, 16'h0000);
    check("nzp_zero", {13'b0, dp.nzp}, 16'h0002);

    // Memory read with latency 3
    mem_write(16'h3005, 16'hBEEF, "wr_lat_3005");
    set_mdr(16'h1111);
    set_mar(16'h3005);
    idle();
    dp.mem_en = 1; dp.mem_rw = 0; dp.ld_mdr = 1; dp.gate_mdr = 1;
    tick();
    for (int k = 0; k <= 4; k++) begin
      check($sformatf("rd_ready_k%0d", k), {15'b0, dp.mem_ready}, (k == 3) ? 16'h0001 : 16'h0000);
      check($sformatf("rd_mdr_k%0d", k), dp.bus, (k == 4) ? 16'hBEEF : 16'h1111);
      if (k < 4) tick();
    end
    idle();

    // Write abort, then full retry
    mem_write(16'h0010, 16'h5555, "wr_lat_0010");
    set_mar(16'h0010);
    set_mdr(16'h1234);
    idle();
    dp.mem_en = 1; dp.mem_rw = 1;
    tick();
    dp.mem_en = 0;
    seen = 0;
    repeat (6) begin
      tick();
      if (dp.mem_ready) seen = 1;
    end
    check("abort_no_ready", {15'b0, seen}, 16'h0000);
    mem_access(1'b0, lat);
    obs(1, 3'd0, v);
    check("abort_mem_kept", v, 16'h5555);
    set_mdr(16'h1234);
    mem_access(1'b1, lat);
    check("retry_lat", 16'(lat), 16'd3);
    set_mdr(16'h0000);
    mem_access(1'b0, lat);
    obs(1, 3'd0, v);
    check("retry_mem", v, 16'h1234);

    // Bus conflict
    check("no_err_yet", {15'b0, dp.bus_err}, 16'h0000);
    set_reg(3'd1, 16'hA5A5);
    idle();
    dp.gate_pc = 1; dp.gate_alu = 1; dp.aluk = ALUK_PASS; dp.sr1 = 3'd1;
    #1;
    check("conflict_bus_pc", dp.bus, 16'h3000);
    tick();
    idle();
    check("bus_err_set", {15'b0, dp.bus_err}, 16'h0001);
    tick();
    check("bus_err_sticky", {15'b0, dp.bus_err}, 16'h0001);

    // BEN and PC path
    set_ir(16'h0402);
    alu_op(ALUK_PASS, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b1);
    check("ben_nzp", {13'b0, dp.nzp}, 16'h0002);
    idle(); dp.ld_ben = 1; tick(); idle();
    check("ben_brz", {15'b0, dp.ben}, 16'h0001);
    set_ir(16'h0802);
    idle(); dp.ld_ben = 1; tick(); idle();
    check("ben_brn", {15'b0, dp.ben}, 16'h0000);
    idle();
    dp.ld_pc = 1; dp.pcmux_sel = PCMUX_ADDR; dp.a1m_sel = 1; dp.a2m_sel = A2M_OFF9;
    tick(); idle();
    obs(0, 3'd0, v);
    check("pc_off9", v, 16'h3002);
    idle(); dp.ld_pc = 1; dp.pcmux_sel = PCMUX_INC; tick(); idle();
    obs(0, 3'd0, v);
    check("pc_inc", v, 16'h3003);
    idle(); dp.ld_pc = 1; dp.pcmux_sel = PCMUX_HOLD; tick(); idle();
    obs(0, 3'd0, v);
    check("pc_hold", v, 16'h3003);
    set_ir(16'h0FFE);
    idle();
    dp.ld_pc = 1; dp.pcmux_sel = PCMUX_ADDR; dp.a1m_sel = 1; dp.a2m_sel = A2M_OFF9;
    tick(); idle();
    obs(0, 3'd0, v);
    check("pc_off9_neg", v, 16'h3001);
    idle(); dp.gate_marmux = 1; dp.marmux_sel = MARMUX_ZEXT8; #1;
    check("marmux_zext", dp.bus, 16'h00FE);
    dp.marmux_sel = MARMUX_ADDR; dp.a1m_sel = 1; dp.a2m_sel = A2M_OFF11; #1;
    check("marmux_off11", dp.bus, 16'h2FFF);
    idle();

    // Async reset in the middle of a write access
    set_mar(16'h0010);
    set_mdr(16'h7777);
    set_ir(16'h0802);
    alu_op(ALUK_NOT, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b1);
    idle(); dp.ld_ben = 1; tick(); idle();
    check("pre_rst_ben", {15'b0, dp.ben}, 16'h0001);
    dp.mem_en = 1; dp.mem_rw = 1;
    tick();
    tick();
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_ir", dp.ir, 16'h0000);
    check("mid_rst_nzp", {13'b0, dp.nzp}, 16'h0002);
    check("mid_rst_ben", {15'b0, dp.ben}, 16'h0000);
    check("mid_rst_bus_err", {15'b0, dp.bus_err}, 16'h0000);
    check("mid_rst_mem_ready", {15'b0, dp.mem_ready}, 16'h0000);
    dp.mem_en = 0;
    dp.gate_pc = 1;
    #1;
    check("mid_rst_pc", dp.bus, 16'h3000);
    dp.gate_pc = 0;
    #2 rst_n = 1'b1;
    tick();
    init_consts();
    set_mar(16'h0010);
    mem_access(1'b0, lat);
    obs(1, 3'd0, v);
    check("rst_drops_write", v, 16'h1234);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
